// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-23 checker: locks onto a received x^23 + x^18 + 1 stream
// and accumulates saturating bit/error counts for BER measurement while locked.
module prbs_checker #(
  parameter int BITS_PER_SYM  = 4,
  parameter int LFSR_WIDTH    = 23,
  parameter int LFSR_TAP_A    = 23,
  parameter int LFSR_TAP_B    = 18,
  parameter int LOCK_THRESH   = 8,
  parameter int UNLOCK_THRESH = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BITS_PER_SYM-1:0] bits_in,
  input  logic                    valid_in,
  input  logic                    clr,
  output logic                    locked,
  output logic                    err_flag,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic [CNT_WIDTH-1:0]    bit_cnt
);

  typedef enum logic {SEARCH, LOCKED} state_e;

  // Symbols needed to fill the history register with received bits.
  localparam int FILL_MAX = (LFSR_WIDTH + BITS_PER_SYM - 1) / BITS_PER_SYM;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);
  localparam int RUN_MAX  = (LOCK_THRESH > UNLOCK_THRESH) ? LOCK_THRESH : UNLOCK_THRESH;
  localparam int RUN_W    = $clog2(RUN_MAX + 1);
  localparam int ERR_W    = $clog2(BITS_PER_SYM + 1);

  state_e                state_q, state_d;
  logic [LFSR_WIDTH-1:0] h_q, h_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;

  logic [LFSR_WIDTH-1:0] h_nxt;
  logic [ERR_W-1:0]      sym_err;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [ERR_W-1:0]     b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  // Unrolled per-bit prediction; oldest bit (MSB) first.
  always_comb begin
    logic [LFSR_WIDTH-1:0] h_walk;
    logic                  e;
    h_walk  = h_q;
    sym_err = '0;
    // NOTE: blocking assignments here model the serial bit-by-bit walk inside one cycle.
    for (int i = BITS_PER_SYM - 1; i >= 0; i--) begin
      e       = h_walk[LFSR_TAP_A-1] ^ h_walk[LFSR_TAP_B-1];
      sym_err = sym_err + ERR_W'(bits_in[i] ^ e);
      h_walk  = {h_walk[LFSR_WIDTH-2:0], (state_q == LOCKED) ? e : bits_in[i]};
    end
    h_nxt = h_walk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      h_q        <= '0;
      fill_q     <= '0;
      run_q      <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all update from pre-edge values.
      state_q    <= state_d;
      h_q        <= h_d;
      fill_q     <= fill_d;
      run_q      <= run_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first, so no latch is inferred.
    state_d    = state_q;
    h_d        = h_q;
    fill_d     = fill_q;
    run_d      = run_q;
    err_flag_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    bit_cnt_d  = bit_cnt_q;

    if (valid_in) begin
      h_d = h_nxt;
      case (state_q)
        SEARCH: begin
          if (fill_q != FILL_W'(FILL_MAX)) begin
            fill_d = fill_q + 1'b1;
            run_d  = '0;
          end else if (sym_err == '0 && h_nxt != '0) begin
            run_d = run_q + 1'b1;
          end else begin
            run_d = '0;
          end
          if (run_d == RUN_W'(LOCK_THRESH)) begin
            state_d = LOCKED;
            run_d   = '0;
          end
        end
        LOCKED: begin
          bit_cnt_d  = sat_add(bit_cnt_q, ERR_W'(BITS_PER_SYM));
          err_cnt_d  = sat_add(err_cnt_q, sym_err);
          err_flag_d = (sym_err != '0);
          run_d      = (sym_err != '0) ? run_q + 1'b1 : '0;
          if (run_d == RUN_W'(UNLOCK_THRESH)) begin
            state_d = SEARCH;
            fill_d  = '0;
            run_d   = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clr) begin
      err_cnt_d  = '0;
      bit_cnt_d  = '0;
      err_flag_d = 1'b0;
    end
  end

  always_comb begin
    locked   = (state_q == LOCKED);
    err_flag = err_flag_q;
    err_cnt  = err_cnt_q;
    bit_cnt  = bit_cnt_q;
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a PRBS-23 source plus a bit-level reference model feeding a
// scoreboard, with a CNT_WIDTH=8 instance sharing the stimulus for saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  bits_in;
  logic        valid_in;
  logic        clr;
  logic        locked, err_flag;
  logic [31:0] err_cnt, bit_cnt;
  logic        locked8, err_flag8;
  logic [7:0]  err_cnt8, bit_cnt8;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .bits_in(bits_in), .valid_in(valid_in), .clr(clr),
    .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs_checker #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bits_in(bits_in), .valid_in(valid_in), .clr(clr),
    .locked(locked8), .err_flag(err_flag8), .err_cnt(err_cnt8), .bit_cnt(bit_cnt8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transmit-side PRBS-23 source, MSB-first per symbol.
  logic [22:0] g;
  function automatic logic [3:0] next_sym();
    logic [3:0] s;
    logic       nb;
    for (int i = 3; i >= 0; i--) begin
      nb   = g[22] ^ g[17];
      g    = {g[21:0], nb};
      s[i] = nb;
    end
    return s;
  endfunction

  // Reference model: bit history as a queue, oldest first.
  bit     m_hist[$];
  bit     m_locked, m_flag;
  int     m_fill, m_run;
  longint m_err, m_bits;

  typedef struct {
    bit     locked;
    bit     flag;
    longint err;
    longint bits;
  } exp_t;
  exp_t sb_q[$];

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < 23; i++) m_hist.push_back(1'b0);
    m_locked = 0; m_flag = 0; m_fill = 0; m_run = 0; m_err = 0; m_bits = 0;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_step(input logic [3:0] rx, input bit v, input bit c);
    int nerr;
    bit e, nz;
    m_flag = 0;
    if (v) begin
      nerr = 0;
      for (int i = 3; i >= 0; i--) begin
        e = m_hist[0] ^ m_hist[5];  // b[k-23] ^ b[k-18]
        if (rx[i] != e) nerr++;
        m_hist.push_back(m_locked ? e : rx[i]);
        void'(m_hist.pop_front());
      end
      nz = 0;
      foreach (m_hist[j]) if (m_hist[j]) nz = 1;
      if (!m_locked) begin
        if (m_fill < 6) begin
          m_fill++;
          m_run = 0;
        end else if (nerr == 0 && nz) m_run++;
        else m_run = 0;
        if (m_run == 8) begin
          m_locked = 1;
          m_run    = 0;
        end
      end else begin
        m_bits += 4;
        m_err  += nerr;
        m_flag  = (nerr != 0);
        m_run   = (nerr != 0) ? m_run + 1 : 0;
        if (m_run == 4) begin
          m_locked = 0;
          m_fill   = 0;
          m_run    = 0;
        end
      end
    end
    if (c) begin
      m_err = 0; m_bits = 0; m_flag = 0;
    end
  endfunction

  // Drive one cycle at the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic [3:0] sym, input bit v, input bit c);
    exp_t x;
    bits_in  = sym;
    valid_in = v;
    clr      = c;
    model_step(sym, v, c);
    sb_q.push_back('{m_locked, m_flag, m_err, m_bits});
    @(posedge clk);
    @(negedge clk);
    x = sb_q.pop_front();
    check("locked",    locked,    x.locked);
    check("err_flag",  err_flag,  x.flag);
    check("err_cnt",   err_cnt,   sat(x.err, 32));
    check("bit_cnt",   bit_cnt,   sat(x.bits, 32));
    check("locked8",   locked8,   x.locked);
    check("err_cnt8",  err_cnt8,  sat(x.err, 8));
    check("bit_cnt8",  bit_cnt8,  sat(x.bits, 8));
    valid_in = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    clr      = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_locked",   locked,   0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_cnt",  err_cnt,  0);
    check("rst_bit_cnt",  bit_cnt,  0);
    rst_n = 1'b1;
  endtask

  // Count valid symbols until lock is observed; bounded by a cycle budget.
  task automatic lock_run(input string tag, input bit gaps);
    int n, cyc;
    bit v;
    n = 0;
    cyc = 0;
    while (!locked && cyc < 1000) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v) begin
        step(next_sym(), 1'b1, 1'b0);
        n++;
      end else begin
        step(4'($urandom), 1'b0, 1'b0);
      end
      cyc++;
    end
    check({tag, "_lock_syms"}, n, 14);
    check({tag, "_locked"}, locked, 1);
  endtask

  initial begin
    bit seen_lock;
    bits_in  = '0;
    valid_in = 1'b0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    g        = 23'h7FFFFF;
    @(negedge clk);
    do_reset();

    // Lock from seed, then 100 counted symbols.
    lock_run("seed", 1'b0);
    check("seed_err0", err_cnt, 0);
    repeat (100) step(next_sym(), 1'b1, 1'b0);
    check("bits_400", bit_cnt, 400);
    check("seed_err_after", err_cnt, 0);

    // Single-bit error must not propagate.
    step(next_sym() ^ 4'b0100, 1'b1, 1'b0);
    check("single_err_cnt", err_cnt, 1);
    check("single_flag", err_flag, 1);
    step(next_sym(), 1'b1, 1'b0);
    check("flag_one_cycle", err_flag, 0);
    check("single_still_locked", locked, 1);
    repeat (5) step(next_sym(), 1'b1, 1'b0);
    check("no_propagation", err_cnt, 1);

    // Loss of lock and re-lock.
    repeat (4) step(next_sym() ^ 4'b1111, 1'b1, 1'b0);
    check("loss_err_cnt", err_cnt, 17);
    check("loss_unlocked", locked, 0);
    lock_run("relock", 1'b0);
    check("relock_err_held", err_cnt, 17);

    // clr coinciding with a counted symbol wins.
    step(next_sym(), 1'b1, 1'b1);
    check("clr_err", err_cnt, 0);
    check("clr_bits", bit_cnt, 0);

    // Saturation of the 8-bit build: 3 bad + 1 clean symbol per round keeps lock.
    for (int r = 0; r < 30; r++) begin
      repeat (3) step(next_sym() ^ 4'b1111, 1'b1, 1'b0);
      step(next_sym(), 1'b1, 1'b0);
    end
    check("sat_err32", err_cnt, 360);
    check("sat_err8", err_cnt8, 255);
    check("sat_bits8", bit_cnt8, 255);
    check("sat_locked", locked, 1);

    // All-zero input never locks.
    do_reset();
    seen_lock = 0;
    for (int i = 0; i < 1000; i++) begin
      step(4'b0000, 1'b1, 1'b0);
      if (locked) seen_lock = 1;
    end
    check("zero_no_lock", seen_lock, 0);

    // Random valid gaps give the same lock point in symbols.
    do_reset();
    lock_run("gaps", 1'b1);
    repeat (10) step(next_sym(), 1'b1, 1'b0);

    // Reset mid-lock.
    do_reset();
    lock_run("post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Self-synchronising PRBS-23 (x^23 + x^18 + 1) checker and bit-error counter for the receive path. It consumes 4-bit demapped symbols from the QAM demapper, locks onto the transmitted PRBS, and accumulates error and bit counts for BER measurement. It is the receive-side counterpart of the transmit PRBS-23 generator, which emits bits MSB-first per symbol.

## Interface
- BITS_PER_SYM, 4, bits per input symbol (gdsp_pkg value).
- LFSR_WIDTH, 23, PRBS register length.
- LFSR_TAP_A, 23, first feedback tap (1-indexed).
- LFSR_TAP_B, 18, second feedback tap (1-indexed).
- LOCK_THRESH, 8, consecutive error-free symbols required to declare lock.
- UNLOCK_THRESH, 4, consecutive errored symbols that drop lock.
- CNT_WIDTH, 32, width of bit and error counters.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- bits_in  in  BITS_PER_SYM  received symbol bits; bit[3] is the oldest in time.
- valid_in  in  1  bits_in qualifier; one symbol per high cycle.
- clr  in  1  synchronous clear of err_cnt, bit_cnt and err_flag; does not affect lock.
- locked  out  1  high while in LOCKED.
- err_flag  out  1  one-cycle pulse: previous LOCKED symbol had at least one bit error.
- err_cnt  out  CNT_WIDTH  total bit errors counted while LOCKED, saturating.
- bit_cnt  out  CNT_WIDTH  total bits compared while LOCKED, saturating.

## Operation
- **Recurrence:** b[k] = b[k-23] ^ b[k-18].
- **History register h[22:0]:** h[0] holds the newest bit. Before each bit, the expected bit is e = h[22] ^ h[17]. After each bit, h is shifted left by one with the new bit entering at h[0].
- **Per valid symbol:** 4 steps are unrolled in order bits_in[3], [2], [1], [0]. The per-bit error is rx ^ e, and the symbol error count (0–4) is the popcount of those four errors.
- **FSM states:** SEARCH, LOCKED. Reset state is SEARCH, with h = 0, fill = 0 and run = 0.
- **SEARCH behaviour:**
  - h shifts in the received bits.
  - fill counts valid symbols and saturates at 6 (24 bits ≥ 23).
  - While fill < 6, no comparison is made and run = 0.
  - Once fill = 6:
    - A clean symbol with h ≠ 0 (judged after the update) increments run.
    - Any errored symbol, or an all-zero h, clears run.
    - When run reaches LOCK_THRESH, go to LOCKED and clear run.
- **LOCKED behaviour:**
  - h shifts in the *expected* bits, so the reference is free-running and a received error never propagates into later predictions.
  - bit_cnt += 4 and err_cnt += the symbol error count, each saturating at 2^CNT_WIDTH−1.
  - An errored symbol increments run; a clean symbol clears run.
  - When run reaches UNLOCK_THRESH, go to SEARCH with fill = 0 and run = 0. Counters hold their values.
- **Counters:** update only on valid_in in LOCKED. The symbol that causes the SEARCH→LOCKED transition is not counted.
- **clr:** if clr and a counted symbol occur in the same cycle, clr wins and the counters become 0.
- **valid_in low:** no state changes, except clr and the clearing of the err_flag pulse.

## Timing
- All outputs are registered. Reset values: locked = 0, err_flag = 0, err_cnt = 0, bit_cnt = 0.
- **Latency:** a symbol sampled at edge N is reflected in locked, err_flag and the counters after edge N, i.e. visible in cycle N+1.
- **Lock timing:** with a continuous error-free stream, locked rises after the edge sampling symbol 6 + LOCK_THRESH (the 14th symbol by default).
- **Unlock timing:** locked falls after the edge sampling the UNLOCK_THRESH-th consecutive errored symbol.
- **Back-to-back symbols:** supported every cycle; there is no backpressure.
- **Reset mid-operation:** immediate return to SEARCH with all registers at reset values.

## Test plan
- **Lock from seed:** drive the TX PRBS-23 generator with seed 0x7FFFFF, valid every cycle -> locked rises in the cycle after the 14th valid symbol; err_cnt = 0; bit_cnt = 400 after 100 further symbols.
- **Single-bit error:** while locked, flip bits_in[2] on one symbol -> err_flag pulses once, err_cnt = 1 (not 3; no propagation), locked stays 1.
- **All-zero input:** 1000 symbols of 4'b0000 -> locked stays 0 throughout.
- **Loss and re-lock:** while locked, inject 4 consecutive symbols each XORed with 4'b1111 -> err_cnt rises by 16 and locked falls after the 4th. Then resume a clean stream -> locked returns after 14 symbols, and err_cnt is unchanged during SEARCH.
- **Gaps, clr, saturation:**
  - Random valid_in gaps (≈50% duty) -> same lock point in symbol count.
  - clr coinciding with a counted symbol -> both counters read 0 the next cycle.
  - Force err_cnt near max (CNT_WIDTH = 8 build) -> it holds at 255.
- **Reset mid-lock:** assert rst_n low for 1 cycle while locked -> all outputs return to 0, and re-lock takes 14 symbols.
